// File: rtl/ssd1306_pkg.sv
// Shared constants for the SSD1306 init sequencer: SPI register map, sequencer
// states and the power-up command list.
package ssd1306_pkg;

    localparam logic [31:0] SPI_CTRL_OFF   = 32'h0000_0000;
    localparam logic [31:0] SPI_TX_OFF     = 32'h0000_0004;
    localparam logic [31:0] SPI_STATUS_OFF = 32'h0000_0008;
    localparam logic [31:0] SPI_CTRL_START = 32'h0000_0001;
    localparam int unsigned STATUS_BUSY_BIT = 0;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RST_LO  = 4'd1,
        S_RST_HI  = 4'd2,
        S_WR_TX   = 4'd3,
        S_WR_CTRL = 4'd4,
        S_POLL    = 4'd5,
        S_NEXT    = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } seq_state_e;

    localparam int unsigned SSD_N_CMDS = 26;
    localparam logic [7:0]  SSD_NOP    = 8'hE3;

    // 128x64 panel bring-up: display off, clocking, mux, offset, charge pump,
    // addressing, remap, COM config, contrast, precharge, VCOMH, resume, display on.
    localparam logic [0:SSD_N_CMDS-1][7:0] SSD_CMDS = {
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'h2E, 8'hAF
    };

endpackage

// File: rtl/ssd1306_cmd_rom.sv
// Combinational command-list lookup; indices past the list return the SSD1306 NOP.
module ssd1306_cmd_rom
    import ssd1306_pkg::*;
#(
    parameter int unsigned IDX_W = 5
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       byte_o
);

    // Table lookup with a harmless fallback for out-of-range indices
    always_comb begin
        byte_o = SSD_NOP;
        if (int'(idx_i) < int'(SSD_N_CMDS)) begin
            byte_o = SSD_CMDS[idx_i];
        end else begin
            byte_o = SSD_NOP;
        end
    end

endmodule

// File: rtl/ssd1306_init_sequencer.sv
// SSD1306 power-up sequencer: pulses RES#, then pushes each command byte through
// the SPI peripheral over OBI, polling STATUS until each transfer drains.
module ssd1306_init_sequencer
    import ssd1306_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned RST_CYCLES = 1000,
    parameter int unsigned POLL_MAX   = 4096,
    parameter int unsigned N_CMDS     = 26
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        req_o,
    output logic [31:0] addr_o,
    output logic        we_o,
    output logic [31:0] wdata_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    output logic        res_n_o,
    output logic        dc_o
);

    localparam int unsigned RST_W  = $clog2(RST_CYCLES + 1);
    localparam int unsigned POLL_W = $clog2(POLL_MAX + 1);
    localparam int unsigned IDX_W  = (N_CMDS > 1) ? $clog2(N_CMDS) : 1;

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CMDS - 1);

    localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + SPI_CTRL_OFF;
    localparam logic [31:0] ADDR_TX     = BASE_ADDR + SPI_TX_OFF;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + SPI_STATUS_OFF;

    seq_state_e        state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              res_n_q, res_n_d;

    logic [IDX_W-1:0]  rom_idx_s;
    logic [7:0]        rom_byte_s;
    logic              resp_s;
    logic              rdata_unused_s;

    // NEXT issues the following TX write in the same cycle it advances the index
    assign rom_idx_s = (state_q == S_NEXT) ? (idx_q + IDX_W'(1)) : idx_q;

    ssd1306_cmd_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .idx_i  (rom_idx_s),
        .byte_o (rom_byte_s)
    );

    // A response only completes the request once it has been granted (possibly this cycle)
    assign resp_s         = rvalid_i && (!req_q || gnt_i);
    assign rdata_unused_s = ^rdata_i;

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        poll_cnt_d = poll_cnt_q;
        idx_d      = idx_q;
        req_d      = req_q && !gnt_i;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        res_n_d    = res_n_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d   = S_RST_LO;
                    rst_cnt_d = '0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    res_n_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RST_LO: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = S_RST_HI;
                    rst_cnt_d = '0;
                    res_n_d   = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_RST_HI: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_WR_TX;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_TX;
                    wdata_d = {24'h00_0000, rom_byte_s};
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_WR_TX: begin
                if (resp_s) begin
                    state_d = S_WR_CTRL;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_CTRL;
                    wdata_d = SPI_CTRL_START;
                end else begin
                    state_d = S_WR_TX;
                end
            end
            S_WR_CTRL: begin
                if (resp_s) begin
                    state_d    = S_POLL;
                    poll_cnt_d = '0;
                    req_d      = 1'b1;
                    we_d       = 1'b0;
                    addr_d     = ADDR_STATUS;
                    wdata_d    = 32'h0000_0000;
                end else begin
                    state_d = S_WR_CTRL;
                end
            end
            S_POLL: begin
                if (!resp_s) begin
                    state_d = S_POLL;
                end else if (!rdata_i[STATUS_BUSY_BIT]) begin
                    state_d = S_NEXT;
                end else if (poll_cnt_q == POLL_LAST) begin
                    state_d = S_ERR;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    poll_cnt_d = poll_cnt_q + POLL_W'(1);
                    req_d      = 1'b1;
                end
            end
            S_NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_WR_TX;
                    idx_d   = idx_q + IDX_W'(1);
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = ADDR_TX;
                    wdata_d = {24'h00_0000, rom_byte_s};
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
                res_n_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rst_cnt_q  <= '0;
            poll_cnt_q <= '0;
            idx_q      <= '0;
            req_q      <= 1'b0;
            addr_q     <= 32'h0000_0000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0000_0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            res_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            idx_q      <= idx_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            res_n_q    <= res_n_d;
        end
    end

    assign req_o   = req_q;
    assign addr_o  = addr_q;
    assign we_o    = we_q;
    assign wdata_o = wdata_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign res_n_o = res_n_q;
    assign dc_o    = 1'b0;

endmodule

// File: tb/tb_ssd1306_init_sequencer.sv
// Randomized bench: OBI slave with random grant/response timing and a STATUS busy
// plan, checked against a transaction-list model built from the command table.
module tb_ssd1306_init_sequencer;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int          R      = 20;
    localparam int          PMAX   = 8;
    localparam int          NC     = 26;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_TX   = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        rst_i, start_i, gnt_i, rvalid_i;
    logic [31:0] rdata_i;
    logic        busy_o, done_o, err_o, req_o, we_o, res_n_o, dc_o;
    logic [31:0] addr_o, wdata_o;

    always #5 clk = ~clk;

    ssd1306_init_sequencer #(
        .BASE_ADDR  (BASE),
        .RST_CYCLES (R),
        .POLL_MAX   (PMAX),
        .N_CMDS     (NC)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .req_o    (req_o),
        .addr_o   (addr_o),
        .we_o     (we_o),
        .wdata_o  (wdata_o),
        .gnt_i    (gnt_i),
        .rvalid_i (rvalid_i),
        .rdata_i  (rdata_i),
        .res_n_o  (res_n_o),
        .dc_o     (dc_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic [7:0] rom_ref [NC] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'h2E, 8'hAF
    };

    txn_t       exp_q [$];
    logic [7:0] tx_log [$];
    logic [7:0] ref_log [$];
    int         busy_plan [NC];
    int         stat_reads [NC];
    bit         err_exp;
    int         cfg_gnt, cfg_lat;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected OBI traffic: per byte TX, CTRL, then (busy+1) STATUS reads, capped at PMAX
    task automatic build_expected();
        int reads;
        bit stop;
        exp_q.delete();
        tx_log.delete();
        err_exp = 1'b0;
        stop = 1'b0;
        for (int k = 0; k < NC; k++) stat_reads[k] = 0;
        for (int k = 0; k < NC; k++) begin
            if (!stop) begin
                exp_q.push_back('{A_TX, 1'b1, {24'h0, rom_ref[k]}});
                exp_q.push_back('{A_CTRL, 1'b1, 32'h1});
                reads = busy_plan[k] + 1;
                if (reads > PMAX) begin
                    reads = PMAX;
                    err_exp = 1'b1;
                    stop = 1'b1;
                end
                for (int j = 0; j < reads; j++) exp_q.push_back('{A_STAT, 1'b0, 32'h0});
            end
        end
    endtask

    // OBI slave plus per-cycle protocol and transaction comparison
    initial begin : bus
        txn_t        cur, held, e;
        bit          have_held, outstanding, was_out, pend;
        int          due, cyc, gwait, lat, bidx, busy_left;
        logic [31:0] pend_rdata, resp, rnd;
        have_held = 0; outstanding = 0; pend = 0;
        due = 0; cyc = 0; gwait = 0; busy_left = 0; pend_rdata = 32'h0;
        gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            gnt_i = 1'b0;
            rvalid_i = 1'b0;
            if (rst_i) begin
                have_held = 0; outstanding = 0; pend = 0;
            end else begin
                check("dc_o", {31'h0, dc_o}, 32'h0);
                was_out = outstanding;
                if (outstanding) check("req_while_outstanding", {31'h0, req_o}, 32'h0);
                if (pend && cyc == due) begin
                    rvalid_i = 1'b1; rdata_i = pend_rdata; pend = 0; outstanding = 0;
                end
                if (req_o && !was_out) begin
                    cur = '{addr_o, we_o, wdata_o};
                    check("busy_during_req", {31'h0, busy_o}, 32'h1);
                    if (have_held) begin
                        check("hold_addr", addr_o, held.addr);
                        check("hold_we", {31'h0, we_o}, {31'h0, held.we});
                        check("hold_wdata", wdata_o, held.wdata);
                    end else begin
                        held = cur; have_held = 1;
                        gwait = (cfg_gnt < 0) ? int'($urandom_range(0, 3)) : cfg_gnt;
                    end
                    if (gwait == 0) begin
                        gnt_i = 1'b1; have_held = 0;
                        if (exp_q.size() == 0) begin
                            vectors++; miscompares++;
                            $display("FAIL extra_txn: got addr 'h%0h we %0d, expected none", cur.addr, cur.we);
                        end else begin
                            e = exp_q.pop_front();
                            check("txn_addr", cur.addr, e.addr);
                            check("txn_we", {31'h0, cur.we}, {31'h0, e.we});
                            if (e.we) check("txn_wdata", cur.wdata, e.wdata);
                        end
                        rnd = $urandom;
                        resp = rnd;
                        if (cur.we && cur.addr == A_TX) begin
                            tx_log.push_back(cur.wdata[7:0]);
                            bidx = tx_log.size() - 1;
                            busy_left = (bidx < NC) ? busy_plan[bidx] : 0;
                        end else if (!cur.we && cur.addr == A_STAT) begin
                            bidx = tx_log.size() - 1;
                            if (bidx >= 0 && bidx < NC) stat_reads[bidx]++;
                            resp = {rnd[31:1], (busy_left > 0)};
                            if (busy_left > 0) busy_left--;
                        end
                        lat = (cfg_lat < 0) ? int'($urandom_range(0, 2)) : cfg_lat;
                        if (lat == 0) begin
                            rvalid_i = 1'b1; rdata_i = resp;
                        end else begin
                            pend = 1; due = cyc + lat; pend_rdata = resp; outstanding = 1;
                        end
                    end else begin
                        gwait--;
                    end
                end else if (have_held) begin
                    check("req_dropped_before_gnt", {31'h0, req_o}, 32'h1);
                    have_held = 0;
                end
            end
        end
    end

    // One start-to-completion sequence; optionally pokes start in WR_TX or aborts in POLL
    task automatic run_seq(input int g, input int l, input bit inject, input bit abort);
        int low_cnt, last_low, first_req;
        bit fin, injected;
        cfg_gnt = g;
        cfg_lat = l;
        build_expected();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        low_cnt = 0; last_low = 0; first_req = 0; fin = 0; injected = 0;
        for (int n = 1; n <= 4000 && !fin; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("start_busy", {31'h0, busy_o}, 32'h1);
                check("start_done_clr", {31'h0, done_o}, 32'h0);
                check("start_err_clr", {31'h0, err_o}, 32'h0);
                check("start_res_n", {31'h0, res_n_o}, 32'h0);
            end
            if (!res_n_o) begin
                low_cnt++;
                last_low = n;
            end
            if (req_o && first_req == 0) first_req = n;
            if (done_o || err_o) begin
                fin = 1;
            end else if (abort && tx_log.size() >= 3 && req_o && !we_o) begin
                @(posedge clk); #1 rst_i = 1'b1;
                @(posedge clk); #1 rst_i = 1'b0;
                @(negedge clk);
                check("abort_req", {31'h0, req_o}, 32'h0);
                check("abort_busy", {31'h0, busy_o}, 32'h0);
                check("abort_res_n", {31'h0, res_n_o}, 32'h1);
                check("abort_done", {31'h0, done_o}, 32'h0);
                return;
            end else if (inject && !injected && req_o && we_o && addr_o == A_TX) begin
                injected = 1;
                @(posedge clk); #1 start_i = 1'b1;
                @(posedge clk); #1 start_i = 1'b0;
            end
        end
        check("completion_in_budget", {31'h0, fin}, 32'h1);
        check("res_n_low_cycles", low_cnt, R);
        check("res_n_low_last", last_low, R);
        check("first_req_cycle", first_req, 2 * R + 1);
        check("done_flag", {31'h0, done_o}, {31'h0, !err_exp});
        check("err_flag", {31'h0, err_o}, {31'h0, err_exp});
        check("busy_end", {31'h0, busy_o}, 32'h0);
        check("txns_left", exp_q.size(), 32'h0);
        if (inject) check("inject_tx_count", tx_log.size(), NC);
    endtask

    initial begin : main
        rst_i = 1'b1;
        start_i = 1'b0;
        cfg_gnt = 0;
        cfg_lat = 1;
        for (int k = 0; k < NC; k++) busy_plan[k] = 0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("rst_req", {31'h0, req_o}, 32'h0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_we", {31'h0, we_o}, 32'h0);
        check("rst_wdata", wdata_o, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        check("rst_res_n", {31'h0, res_n_o}, 32'h1);

        // zero-wait slave, STATUS never busy
        run_seq(0, 1, 0, 0);
        check("tx_count", tx_log.size(), 32'd26);
        check("tx_first", {24'h0, tx_log[0]}, 32'hAE);
        check("tx_byte3", {24'h0, tx_log[3]}, 32'hA8);
        check("tx_last", {24'h0, tx_log[25]}, 32'hAF);
        ref_log = tx_log;

        // grant delayed by 3 cycles; start pulsed in WR_TX must be ignored
        run_seq(3, 1, 1, 0);
        check("gnt3_count", tx_log.size(), ref_log.size());
        for (int k = 0; k < NC; k++) check("gnt3_stream", {24'h0, tx_log[k]}, {24'h0, ref_log[k]});

        // busy for 5 reads on byte 3, boundary 7 busy (8 reads) on byte 10
        busy_plan[3] = 5;
        busy_plan[10] = 7;
        run_seq(0, 0, 0, 0);
        check("byte3_status_reads", stat_reads[3], 32'd6);
        check("byte10_status_reads", stat_reads[10], 32'd8);
        for (int k = 0; k < NC; k++) busy_plan[k] = 0;

        // STATUS stuck busy on byte 0
        busy_plan[0] = 1000;
        run_seq(0, 1, 0, 0);
        check("stuck_status_reads", stat_reads[0], 32'd8);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("err_idle_req", {31'h0, req_o}, 32'h0);
            check("err_hold", {31'h0, err_o}, 32'h1);
        end
        busy_plan[0] = 0;
        run_seq(0, 1, 0, 0);

        // synchronous reset during POLL, then a clean full run
        run_seq(-1, -1, 0, 1);
        repeat (3) @(negedge clk);
        run_seq(0, 1, 0, 0);
        check("post_abort_tx_count", tx_log.size(), 32'd26);

        // randomized timing and busy plans, occasionally forcing a timeout
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NC; k++)
                busy_plan[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : 0;
            if ($urandom_range(0, 2) == 0) busy_plan[$urandom_range(0, NC - 1)] = 8;
            run_seq(-1, -1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
